// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared definitions for the float encode/decode units: one-hot class codes,
// exponent constants, the encoder state enum and a one-hot check helper.
// -----------------------------------------------------------------------------
package float_pkg;

    localparam logic [4:0] TYPE_ZERO    = 5'b00001;
    localparam logic [4:0] TYPE_NORMAL  = 5'b00010;
    localparam logic [4:0] TYPE_SUBNORM = 5'b00100;
    localparam logic [4:0] TYPE_INF     = 5'b01000;
    localparam logic [4:0] TYPE_NAN     = 5'b10000;

    localparam logic [7:0] EXP_BIAS    = 8'd127;
    // Biased exponent of a value whose leading one sits in bit 31 (127 + 31).
    localparam logic [7:0] EXP_INT_TOP = 8'd158;
    localparam logic [7:0] EXP_ALL1    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when exactly one bit of the class code is set.
    function automatic logic is_onehot(input logic [4:0] t);
        return (t != 5'd0) && ((t & (t - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/float_round_rne.sv
// -----------------------------------------------------------------------------
// float_round_rne
// Combinational round-to-nearest-even of a normalized 32-bit magnitude
// (leading one in bit 31) down to a 23-bit fraction.
// Ports:
//   e_i    : biased exponent before rounding
//   m_i    : normalized magnitude, m_i[31] is the hidden bit
//   e_o    : exponent after rounding (incremented on fraction carry-out)
//   mant_o : rounded 23-bit fraction
// -----------------------------------------------------------------------------
module float_round_rne
    import float_pkg::*;
(
    input  logic [7:0]  e_i,
    input  logic [31:0] m_i,
    output logic [7:0]  e_o,
    output logic [22:0] mant_o
);

    logic        guard_s;
    logic        sticky_s;
    logic        inc_s;
    logic [23:0] sum_s;

    // Guard/sticky rounding decision and fraction increment.
    always_comb begin
        guard_s  = m_i[7];
        sticky_s = |m_i[6:0];
        inc_s    = guard_s && (sticky_s || m_i[8]);
        sum_s    = {1'b0, m_i[30:8]} + {23'd0, inc_s};
        if (sum_s[23]) begin
            // Fraction overflowed: value becomes 2^(e+1) with a zero fraction.
            mant_o = 23'd0;
            e_o    = e_i + 8'd1;
        end else begin
            mant_o = sum_s[22:0];
            e_o    = e_i;
        end
    end

endmodule

// File: rtl/float_encoder.sv
// -----------------------------------------------------------------------------
// float_encoder
// Builds an IEEE-754 single-precision word from a one-hot class code, a sign
// and a 32-bit unsigned magnitude. Normal-class magnitudes are normalized and
// rounded to nearest-even. valid/ready handshake on both sides.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   in_type             : one-hot class code (zero/normal/subnormal/inf/NaN)
//   in_sign             : sign of the result
//   in_int              : magnitude (normal) or raw fraction in [22:0] (subnormal)
//   out_valid/out_ready : result handshake
//   out_float, out_type : encoded word and its class
// Build option:
//   FLOAT_ENC_FAST_NORM_EN : normalize in a single cycle with a leading-zero
//                            count instead of one bit per cycle.
// -----------------------------------------------------------------------------
module float_encoder
    import float_pkg::*;
#(
    parameter logic [22:0] QNAN_MANT = 23'h400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_type,
    input  logic        in_sign,
    input  logic [31:0] in_int,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic [4:0]  out_type
);

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] m_q, m_d;
    logic [7:0]  e_q, e_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_float_q, out_float_d;
    logic [4:0]  out_type_q, out_type_d;

    logic [7:0]  rnd_e_s;
    logic [22:0] rnd_mant_s;

    float_round_rne u_round (
        .e_i    (e_q),
        .m_i    (m_q),
        .e_o    (rnd_e_s),
        .mant_o (rnd_mant_s)
    );

`ifdef FLOAT_ENC_FAST_NORM_EN
    logic [4:0] lz_s;

    // Leading-zero count of the working magnitude (nonzero whenever used).
    always_comb begin
        lz_s = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (m_q[i]) begin
                lz_s = 5'(31 - i);
            end else begin
                lz_s = lz_s;
            end
        end
    end
`endif

    // Next-state, datapath and output computation.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        m_d         = m_q;
        e_d         = e_q;
        out_valid_d = out_valid_q;
        out_float_d = out_float_q;
        out_type_d  = out_type_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d      = in_sign;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    if (!is_onehot(in_type)) begin
                        // Invalid class code: canonical positive quiet NaN.
                        out_float_d = {1'b0, EXP_ALL1, QNAN_MANT};
                        out_type_d  = TYPE_NAN;
                    end else begin
                        case (in_type)
                            TYPE_ZERO: begin
                                out_float_d = {in_sign, 31'd0};
                                out_type_d  = TYPE_ZERO;
                            end
                            TYPE_NORMAL: begin
                                if (in_int == 32'd0) begin
                                    out_float_d = {in_sign, 31'd0};
                                    out_type_d  = TYPE_ZERO;
                                end else begin
                                    state_d     = ST_NORM;
                                    out_valid_d = 1'b0;
                                    m_d         = in_int;
                                    e_d         = EXP_INT_TOP;
                                end
                            end
                            TYPE_SUBNORM: begin
                                if (in_int[22:0] != 23'd0) begin
                                    out_float_d = {in_sign, 8'h00, in_int[22:0]};
                                    out_type_d  = TYPE_SUBNORM;
                                end else begin
                                    out_float_d = {in_sign, 31'd0};
                                    out_type_d  = TYPE_ZERO;
                                end
                            end
                            TYPE_INF: begin
                                out_float_d = {in_sign, EXP_ALL1, 23'd0};
                                out_type_d  = TYPE_INF;
                            end
                            TYPE_NAN: begin
                                out_float_d = {in_sign, EXP_ALL1, QNAN_MANT};
                                out_type_d  = TYPE_NAN;
                            end
                            default: begin
                                out_float_d = {1'b0, EXP_ALL1, QNAN_MANT};
                                out_type_d  = TYPE_NAN;
                            end
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
`ifdef FLOAT_ENC_FAST_NORM_EN
                m_d     = m_q << lz_s;
                e_d     = e_q - {3'd0, lz_s};
                state_d = ST_ROUND;
`else
                if (m_q[31]) begin
                    state_d = ST_ROUND;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 8'd1;
                end
`endif
            end
            ST_ROUND: begin
                // Exponent tops out at 159 here, so the result is always finite.
                out_float_d = {sign_q, rnd_e_s, rnd_mant_s};
                out_type_d  = TYPE_NORMAL;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            m_q         <= 32'd0;
            e_q         <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_float_q <= 32'd0;
            out_type_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            m_q         <= m_d;
            e_q         <= e_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_float_q <= out_float_d;
            out_type_q  <= out_type_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_float = out_float_q;
    assign out_type  = out_type_q;

endmodule

// File: doc/float_encoder.md
Name: float_encoder

Overview:
- Builds an IEEE-754 single-precision word from a class code, a sign and a 32-bit magnitude.
- This is the encode direction of the float classifier: class codes use the same one-hot encoding.
- Normal class: the unsigned integer magnitude is converted with an iterative normalizer and round-to-nearest-even.
- Sits between integer datapath producers and float consumers, with valid/ready on both sides.

Parameters:
QNAN_MANT, 23'h400000, mantissa emitted for NaN class and for invalid class codes

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
in_type  input  5  one-hot class code: 00001 zero, 00010 normal, 00100 subnormal, 01000 inf, 10000 NaN
in_sign  input  1  sign bit of the result
in_int  input  32  unsigned magnitude for normal; [22:0] is the raw mantissa for subnormal
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_float  output  32  encoded float
out_type  output  5  class of the emitted word, same encoding

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset: state IDLE; out_valid=0, out_float=0, out_type=0, internal regs 0; in_ready=1 after release. Reset mid-operation aborts the request silently. Inputs are ignored while reset is high.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at the clock edge, latching sign, type and int.
- Zero class: go to DONE with {sign,31'b0}, type 00001.
- Inf class: go to DONE with {sign,8'hFF,23'b0}, type 01000.
- NaN class: go to DONE with {sign,8'hFF,QNAN_MANT}, type 10000.
- Subnormal class:
  - in_int[22:0]!=0: DONE with {sign,8'h00,in_int[22:0]}, type 00100.
  - in_int[22:0]==0: {sign,31'b0}, type 00001.
- Invalid class (not exactly one-hot, including 0): {1'b0,8'hFF,QNAN_MANT}, type 10000.
- Normal class:
  - in_int==0: same as zero class.
  - Otherwise go to NORM with m=in_int, e=8'd158.
- NORM:
  - m[31]==1: go to ROUND.
  - Otherwise m<=m<<1, e<=e-1.
- ROUND:
  - mant=m[30:8], guard=m[7], sticky=|m[6:0].
  - Increment when guard && (sticky || mant[0]).
  - Mantissa carry-out: mant=0, e=e+1. Max e=159, so inf is never produced.
  - Result {sign,e,mant}, type 00010; go to DONE.
- DONE: out_valid=1; out_float and out_type held stable until out_ready. On the handshake go to IDLE with out_valid=0. in_ready=0 in DONE, so there is no same-cycle accept.
- Latency from accept edge to out_valid high:
  - Special, subnormal and invalid classes: 1 cycle.
  - Normal: 3 + lz(in_int) cycles, i.e. 3..34.

Optional Feature:
FLOAT_ENC_FAST_NORM_EN
- Defined: NORM performs the full shift in one cycle using a leading-zero count (m<<lz, e=158-lz), then goes to ROUND. Normal latency is a fixed 3 cycles.
- Undefined: NORM is the one-bit-per-cycle iteration above.
- Results are bit-identical in both builds.

Decomposition:
- Package float_pkg:
  - Class code constants: TYPE_ZERO, TYPE_NORMAL, TYPE_SUBNORM, TYPE_INF, TYPE_NAN.
  - EXP_BIAS=127, EXP_INT_TOP=158, EXP_ALL1=8'hFF.
  - State enum.
- Sub-module float_round_rne: combinational; takes {e, m}, returns {e', mant}. Shared with future float units.
- The leading-zero counter stays inline.

Test Plan:
- Normal, sign=0, int=32'h1 -> out_float=32'h3F800000, out_type=00010; out_valid 34 cycles after accept (3 with FLOAT_ENC_FAST_NORM_EN).
- Normal, sign=1, int=32'h01000001 (tie, even) -> 32'hCB800000.
- Normal, sign=0, int=32'h01000003 (tie, odd, round up) -> 32'h4B800002.
- Normal, int=32'hFFFFFFFF (round carry) -> 32'h4F800000.
- Inf, sign=1 -> 32'hFF800000, type 01000, 1-cycle latency; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Invalid type 00110 -> 32'h7FC00000, type 10000; subnormal with int=0, sign=1 -> 32'h80000000, type 00001.
- Reset asserted mid-NORM -> out_valid=0, in_ready=1 after release; the next request int=32'h80000000 -> 32'h4F000000.
